// File: rtl/dmem_write_buffer_if.sv
// Bus between the MEM stage and the data-memory write buffer.
//   memwrite  : store request, sampled at clk rise
//   dataadr   : byte address for load/store
//   writedata : store data
//   readdata  : combinational load data
//   stall     : store cannot be accepted this cycle
//   busy      : buffer non-empty or a drain is in flight
//   count     : buffer occupancy
// master = core side, slave = memory side.
interface dmem_write_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          memwrite;
  logic [31:0]   dataadr;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          stall;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output memwrite, dataadr, writedata,
    input  readdata, stall, busy, count
  );

  modport slave (
    input  memwrite, dataadr, writedata,
    output readdata, stall, busy, count
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Data-memory responder for the MEM stage. Stores go into a FIFO write
// buffer and are drained into a word-addressed RAM by a two-state FSM
// (IDLE/WRITE) that spends WRLAT cycles per commit. Loads read the RAM
// combinationally, with the youngest matching buffered store forwarded.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (buffer/FSM only, RAM untouched)
//   bus   : slave side of dmem_write_buffer_if
module dmem_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int MEMWORDS = 64,
  parameter int WRLAT    = 2
) (
  input logic                 clk,
  input logic                 reset,
  dmem_write_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(MEMWORDS);
  localparam int LW = (WRLAT > 1) ? $clog2(WRLAT) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               head_q, head_d;
  logic [PW-1:0]               tail_q, tail_d;
  logic [CW-1:0]               count_q, count_d;
  logic [LW-1:0]               lat_q, lat_d;
  logic [IW-1:0]               wr_idx_q, wr_idx_d;
  logic [31:0]                 wr_data_q, wr_data_d;
  logic                        busy_q, busy_d;
  logic [DEPTH-1:0][IW-1:0]    ent_idx_q, ent_idx_d;
  logic [DEPTH-1:0][31:0]      ent_data_q, ent_data_d;

  logic [31:0] ram [MEMWORDS];

  logic [IW-1:0] idx;
  logic          full, push, pop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_adr;

  // Address bits outside the word index carry no meaning here.
  assign unused_adr = ^{bus.dataadr[31:IW+2], bus.dataadr[1:0]};

  assign idx  = bus.dataadr[IW+1:2];
  assign full = (count_q == CW'(DEPTH));
  // Full buffer stalls even when the head pops this cycle.
  assign push = bus.memwrite & ~full;
  assign pop  = (state_q == WRITE) && (lat_q == '0);

  assign bus.stall = bus.memwrite & full;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

  // Forwarding: walk valid slots oldest to youngest so the last hit wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot     = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_idx_q[slot] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[slot];
      end
    end
  end

  assign bus.readdata = fwd_hit ? fwd_data : ram[idx];

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    lat_d      = lat_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    ent_idx_d  = ent_idx_q;
    ent_data_d = ent_data_q;

    if (push) begin
      ent_idx_d[tail_q]  = idx;
      ent_data_d[tail_q] = bus.writedata;
      tail_d             = tail_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = WRITE;
          lat_d     = LW'(WRLAT - 1);
          wr_idx_d  = ent_idx_q[head_q];
          wr_data_d = ent_data_q[head_q];
        end
      end
      WRITE: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          head_d  = head_q + PW'(1);
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    busy_d = (count_d != '0) | (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      lat_q      <= '0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      ent_idx_q  <= '0;
      ent_data_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      lat_q      <= lat_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      ent_idx_q  <= ent_idx_d;
      ent_data_q <= ent_data_d;
    end
  end

  // RAM keeps its contents across reset; pop is low while reset holds the
  // FSM in IDLE, so an interrupted drain never lands.
  always_ff @(posedge clk) begin
    if (pop) ram[wr_idx_q] <= wr_data_q;
  end
endmodule

// File: tb/tb_dmem_write_buffer.sv
module tb_dmem_write_buffer;
  localparam int DEPTH = 4, MEMWORDS = 64, WRLAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dmem_write_buffer_if #(.DEPTH(DEPTH)) bif();

  dmem_write_buffer #(.DEPTH(DEPTH), .MEMWORDS(MEMWORDS), .WRLAT(WRLAT)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );

  always #5 clk = ~clk;

  // Reference model: pending stores in order, RAM image, drain timer.
  typedef struct { int idx; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] ram_m [MEMWORDS];
  bit          known [MEMWORDS];
  bit          active;
  int          commit_at, cyc;

  int total = 0, bad = 0;
  logic [31:0] obs_rd, obs_cnt;
  logic        obs_stall, obs_busy, stall_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] adr);
    return int'((adr >> 2) % MEMWORDS);
  endfunction

  function automatic bit m_has(input int idx);
    foreach (q[i]) if (q[i].idx == idx) return 1'b1;
    return known[idx];
  endfunction

  function automatic logic [31:0] m_rd(input int idx);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].idx == idx) return q[i].data;
    return ram_m[idx];
  endfunction

  // One clock cycle: present inputs, check outputs at negedge, then advance
  // the model across the rising edge.
  task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                      output logic acc);
    logic exp_stall;
    ent_t e;
    bif.memwrite = mw; bif.dataadr = adr; bif.writedata = wd;
    @(negedge clk);
    exp_stall = mw && (q.size() == DEPTH);
    obs_rd = bif.readdata; obs_cnt = 32'(bif.count);
    obs_stall = bif.stall; obs_busy = bif.busy;
    if (obs_stall) stall_seen = 1'b1;
    chk("stall", 32'(obs_stall), 32'(exp_stall));
    chk("count", obs_cnt, q.size());
    chk("busy", 32'(obs_busy), 32'((q.size() != 0) || active));
    if (m_has(widx(adr))) chk("readdata", obs_rd, m_rd(widx(adr)));
    @(posedge clk);
    if (active && cyc == commit_at) begin
      e = q.pop_front();
      ram_m[e.idx] = e.data; known[e.idx] = 1'b1; active = 1'b0;
    end else if (!active && q.size() > 0) begin
      active = 1'b1; commit_at = cyc + WRLAT;
    end
    acc = mw && !exp_stall;
    if (acc) begin e.idx = widx(adr); e.data = wd; q.push_back(e); end
    cyc++;
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] wd);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, adr, wd, a);
    chk("store_accepted", 32'(a), 32'd1);
  endtask

  task automatic drain(input logic [31:0] adr);
    logic a;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && !active) break;
      step(1'b0, adr, 32'd0, a);
    end
    chk("drain_done", 32'(bif.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [31:0] prior, adr;
    active = 0; cyc = 0; stall_seen = 0;
    foreach (known[i]) known[i] = 1'b0;
    bif.memwrite = 0; bif.dataadr = 0; bif.writedata = 0;

    // Reset state
    #1 reset = 1'b1;
    @(posedge clk); #1;
    bif.memwrite = 1'b1;
    #1;
    chk("rst_count", 32'(bif.count), 0);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_stall", 32'(bif.stall), 0);
    bif.memwrite = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Fill every RAM word with known data
    for (int w = 0; w < MEMWORDS; w++) store(32'(w * 4), $urandom());
    drain(32'd0);

    // Reset mid-drain: the interrupted store must not reach RAM
    prior = ram_m[21];
    store(32'd84, 32'd4859);
    step(1'b0, 32'd84, 32'd0, a);          // drain starts at this edge
    #2 reset = 1'b1; bif.memwrite = 1'b1;
    #1;
    chk("middrain_count", 32'(bif.count), 0);
    chk("middrain_busy", 32'(bif.busy), 0);
    chk("middrain_stall", 32'(bif.stall), 0);
    bif.memwrite = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    q.delete(); active = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 32'd84, 32'd0, a);
    chk("middrain_ram_kept", obs_rd, prior);

    // Single store: forwarded at once, commits three edges later
    store(32'd84, 32'd4859);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 32'd84, 32'd0, a);
      chk("single_rd", obs_rd, 32'd4859);
      chk("single_cnt", obs_cnt, (k <= 3) ? 32'd1 : 32'd0);
      chk("single_busy", 32'(obs_busy), (k <= 3) ? 32'd1 : 32'd0);
    end

    // Overflow
    for (int k = 0; k < 5; k++) store(32'(k * 4), 32'h100 + 32'(k));
    stall_seen = 1'b0;
    for (int k = 0; k < 8; k++) store(32'h80 + 32'(k * 4), 32'h200 + 32'(k));
    chk("ovf_stall_seen", 32'(stall_seen), 32'd1);
    drain(32'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'(k * 4), 32'd0, a);
      chk("ovf_ram", obs_rd, 32'h100 + 32'(k));
    end

    // Forwarding priority
    store(32'd80, 32'd7);
    store(32'd80, 32'd9);
    step(1'b0, 32'd80, 32'd0, a);
    chk("fwd_young", obs_rd, 32'd9);
    step(1'b0, 32'd76, 32'd0, a);
    chk("fwd_other", obs_rd, ram_m[19]);
    drain(32'd80);
    step(1'b0, 32'd80, 32'd0, a);
    chk("fwd_after_drain", obs_rd, 32'd9);

    // Alignment
    store(32'd86, 32'hA5A5A5A5);
    step(1'b0, 32'd84, 32'd0, a);
    chk("align", obs_rd, 32'hA5A5A5A5);
    drain(32'd84);

    // Continuous stores starting from two buffered entries
    store(32'h200, 32'h300);
    store(32'h204, 32'h301);
    for (int k = 2; k < 22; k++) begin
      store(32'h200 + 32'(k * 4), 32'h300 + 32'(k));
      chk("pp_cnt_le_depth", 32'(obs_cnt <= DEPTH), 32'd1);
    end
    drain(32'h200);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      adr = $urandom();
      step(($urandom_range(0, 9) < 7), adr, $urandom(), a);
      chk("rnd_cnt_le_depth", 32'(obs_cnt <= DEPTH), 32'd1);
    end
    drain(32'd0);

    // Final scoreboard sweep of the whole RAM
    for (int w = 0; w < MEMWORDS; w++) begin
      step(1'b0, 32'(w * 4), 32'd0, a);
      chk("final_ram", obs_rd, ram_m[w]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
